// File: rtl/regs_pkg.sv
// Shared types and helpers for the multi-port register file.
// Forwarding select is only consumed when REGS_BYPASS_EN is defined.
package regs_pkg;

  typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} st_e;

  typedef enum logic [1:0] {FWD_MEM, FWD_W0, FWD_W1} fwd_e;

  // Addresses are zero-extended to this width before entering the helper below.
  localparam int unsigned MAX_ADDR_W = 16;
  localparam logic [MAX_ADDR_W-1:0] ZERO_ADDR = '0;

  // W1 is checked last so it overrides W0 on a shared address.
  function automatic fwd_e fwd_sel(input logic [MAX_ADDR_W-1:0] rd_addr,
                                   input logic                  w0_ok,
                                   input logic [MAX_ADDR_W-1:0] w0_addr,
                                   input logic                  w1_ok,
                                   input logic [MAX_ADDR_W-1:0] w1_addr);
    fwd_e sel;
    sel = FWD_MEM;
    if (w0_ok && (w0_addr == rd_addr)) sel = FWD_W0;
    if (w1_ok && (w1_addr == rd_addr)) sel = FWD_W1;
    return sel;
  endfunction

endpackage

// File: rtl/regs_clr_seq.sv
// Clear-sweep sequencer: walks every entry once, writing zero, after reset or on request.
module regs_clr_seq
  import regs_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] CNT_MAX = {ADDR_W{1'b1}};

  st_e               state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    clr_we   = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr_busy = 1'b1;
        clr_we   = 1'b1;
        // A new request aborts the current sweep without signalling completion.
        if (clr_req) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          clr_done = 1'b1;
          state_d  = ST_IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD read ports, ALU (W0) and load (W1) write ports, debug read.
// Define REGS_BYPASS_EN for write-first forwarding; otherwise reads return pre-write contents.
module regfile_mp
  import regs_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic                  w0_en,
  input  logic [ADDR_W-1:0]     w0_addr,
  input  logic [DATA_W-1:0]     w0_data,
  input  logic                  w1_en,
  input  logic [ADDR_W-1:0]     w1_addr,
  input  logic [DATA_W-1:0]     w1_data,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  wr_drop,
  input  logic [ADDR_W-1:0]     dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              w0_live, w1_live, w0_ok, w1_ok;
  logic              wr_drop_q;

  regs_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Writes to a hard-wired zero entry vanish without counting as drops.
  assign w0_live = w0_en && !((ZERO_REG != 0) && (MAX_ADDR_W'(w0_addr) == ZERO_ADDR));
  assign w1_live = w1_en && !((ZERO_REG != 0) && (MAX_ADDR_W'(w1_addr) == ZERO_ADDR));
  assign w0_ok   = w0_live && !clr_busy && !(w1_live && (w1_addr == w0_addr));
  assign w1_ok   = w1_live && !clr_busy;

  // Storage has no reset; the sweep zeroes it and reads are masked until it finishes.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs[clr_addr] <= '0;
    end else begin
      if (w0_ok) regs[w0_addr] <= w0_data;
      if (w1_ok) regs[w1_addr] <= w1_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= clr_busy && (w0_en || w1_en);
    end
  end

  assign wr_drop = wr_drop_q;

  // Ports 0..NRD-1 are the data read ports; port NRD is the debug port.
  for (genvar k = 0; k <= NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] q;

    if (k < NRD) begin : g_data_port
      assign addr                        = rd_addr[k*ADDR_W +: ADDR_W];
      assign rd_data[k*DATA_W +: DATA_W] = q;
    end else begin : g_dbg_port
      assign addr     = dbg_addr;
      assign dbg_data = q;
    end

    always_comb begin
      q = regs[addr];
`ifdef REGS_BYPASS_EN
      unique case (fwd_sel(MAX_ADDR_W'(addr), w0_ok, MAX_ADDR_W'(w0_addr),
                           w1_ok, MAX_ADDR_W'(w1_addr)))
        FWD_W0:  q = w0_data;
        FWD_W1:  q = w1_data;
        default: q = regs[addr];
      endcase
`endif
      if (clr_busy || ((ZERO_REG != 0) && (MAX_ADDR_W'(addr) == ZERO_ADDR))) q = '0;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with a cycle-level reference model and a per-cycle compare.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NRD*AW-1:0] rd_addr = '0;
  logic [NRD*DW-1:0] rd_data;
  logic              w0_en = 1'b0;
  logic [AW-1:0]     w0_addr = '0;
  logic [DW-1:0]     w0_data = '0;
  logic              w1_en = 1'b0;
  logic [AW-1:0]     w1_addr = '0;
  logic [DW-1:0]     w1_data = '0;
  logic              clr_req = 1'b0;
  logic              clr_busy, clr_done, wr_drop;
  logic [AW-1:0]     dbg_addr = 5'd5;
  logic [DW-1:0]     dbg_data;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  regfile_mp #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NRD      (NRD),
    .ZERO_REG (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .w0_en    (w0_en),
    .w0_addr  (w0_addr),
    .w0_data  (w0_data),
    .w1_en    (w1_en),
    .w1_addr  (w1_addr),
    .w1_data  (w1_data),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .wr_drop  (wr_drop),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  // Reference model: contents plus number of sweep cycles still to run.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_left = DEPTH;
  logic          m_drop = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left <= DEPTH;
      m_drop <= 1'b0;
    end else if (m_left > 0) begin
      m_mem[DEPTH - m_left] <= '0;
      m_drop <= w0_en | w1_en;
      m_left <= clr_req ? DEPTH : m_left - 1;
    end else begin
      m_drop <= 1'b0;
      if (w0_en && w0_addr != 0 && !(w1_en && w1_addr == w0_addr)) m_mem[w0_addr] <= w0_data;
      if (w1_en && w1_addr != 0) m_mem[w1_addr] <= w1_data;
      if (clr_req) m_left <= DEPTH;
    end
  end

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (m_left > 0 || a == 0) return '0;
`ifdef REGS_BYPASS_EN
    if (w1_en && w1_addr == a) return w1_data;
    if (w0_en && w0_addr == a) return w0_data;
`endif
    return m_mem[a];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < NRD; k++) begin
        check($sformatf("rd_data[%0d]", k), 64'(rd_data[k*DW +: DW]),
              64'(exp_read(rd_addr[k*AW +: AW])));
      end
      check("dbg_data", 64'(dbg_data), 64'(exp_read(dbg_addr)));
      check("clr_busy", 64'(clr_busy), 64'(m_left > 0));
      check("clr_done", 64'(clr_done), 64'(m_left == 1 && !clr_req));
      check("wr_drop", 64'(wr_drop), 64'(m_drop));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w0_en   = 1'b0;
    w1_en   = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    w0_en = 1'b1; w0_addr = a; w0_data = d;
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    w1_en = 1'b1; w1_addr = a; w1_data = d;
  endtask

  // Counts cycles from the current one up to and including the clr_done cycle.
  task automatic wait_done(input string name, input int exp_n);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!clr_done && n < 200);
    if (n >= 200) check({name, "_timeout"}, 64'(clr_done), 64'(1));
    else          check(name, 64'(n), 64'(exp_n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and first sweep.
    repeat (2) step();
    chk_on = 1'b1;
    check("reset_busy", 64'(clr_busy), 64'(1));
    check("reset_drop", 64'(wr_drop), 64'(0));
    rst = 1'b1;
    wait_done("first_sweep_len", 32);
    step();
    check("busy_after_sweep", 64'(clr_busy), 64'(0));

    // Plain write, then a write to the zero register.
    rd_addr = {5'd0, 5'd5};
    wr0(5'd5, 32'hDEADBEEF);
    step(); idle();
    check("rd_after_write", 64'(rd_data[31:0]), 64'h0000_0000_DEAD_BEEF);
    wr0(5'd0, 32'h1234);
    rd_addr = {5'd0, 5'd0};
    step(); idle();
    check("zero_reg_read", 64'(rd_data[31:0]), 64'(0));
    check("zero_reg_nodrop", 64'(wr_drop), 64'(0));

    // Same-address collision, then independent dual write.
    wr0(5'd7, 32'h11); wr1(5'd7, 32'h22);
    step(); idle();
    rd_addr = {5'd0, 5'd7};
    #1 check("w1_wins", 64'(rd_data[31:0]), 64'h22);
    check("collision_nodrop", 64'(wr_drop), 64'(0));
    wr0(5'd3, 32'h33); wr1(5'd4, 32'h44);
    step(); idle();
    rd_addr = {5'd4, 5'd3};
    #1 check("dual_w0", 64'(rd_data[31:0]), 64'h33);
    check("dual_w1", 64'(rd_data[63:32]), 64'h44);

    // Write dropped mid-sweep; entry 9 ends up cleared.
    wr0(5'd9, 32'hAB);
    step(); idle();
    clr_req = 1'b1;
    step(); idle();
    repeat (10) step();
    wr0(5'd9, 32'hAA);
    step(); idle();
    check("drop_mid_sweep", 64'(wr_drop), 64'(1));
    wait_done("sweep_tail_len", 21);
    step();
    rd_addr = {5'd0, 5'd9};
    #1 check("reg9_cleared", 64'(rd_data[31:0]), 64'(0));

    // Restart at cnt=15: a full sweep follows with no done for the aborted one.
    clr_req = 1'b1;
    step(); idle();
    repeat (15) step();
    clr_req = 1'b1;
    step(); idle();
    wait_done("restart_sweep_len", 32);
    step();

    // Read port 1 during a W1 write to the same address.
    wr0(5'd12, 32'h66);
    step(); idle();
    rd_addr = {5'd12, 5'd0};
    wr1(5'd12, 32'h55);
    #1;
`ifdef REGS_BYPASS_EN
    check("rdw_same_cycle", 64'(rd_data[63:32]), 64'h55);
`else
    check("rdw_same_cycle", 64'(rd_data[63:32]), 64'h66);
`endif
    step(); idle();
    check("rdw_after_edge", 64'(rd_data[63:32]), 64'h55);

    // Reset mid-sweep and mid-write.
    clr_req = 1'b1;
    step(); idle();
    repeat (20) step();
    wr0(5'd2, 32'h77);
    wr1(5'd6, 32'h88);
    step();
    check("drop_before_reset", 64'(wr_drop), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("async_rst_busy", 64'(clr_busy), 64'(1));
    check("async_rst_done", 64'(clr_done), 64'(0));
    check("async_rst_drop", 64'(wr_drop), 64'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    idle();
    wait_done("post_reset_sweep_len", 32);
    step();
    rd_addr = {5'd6, 5'd3};
    #1 check("reg3_after_reset", 64'(rd_data[31:0]), 64'(0));
    check("reg6_after_reset", 64'(rd_data[63:32]), 64'(0));
    step();

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
